// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and sequencer state encoding for the register bank.
package register_file_pkg;
  localparam int REG_DATA_WIDTH = 8;
  localparam int DEFAULT_POINTER_WIDTH = 3;
  typedef enum logic [1:0] {IDLE, LOAD, DUMP_READ, DUMP_SEND} seq_state_t;
endpackage

// File: rtl/register_file_sequencer.sv
// register_file_sequencer: bulk-loads or bulk-dumps a register_file bank over a byte stream.
module register_file_sequencer
  import register_file_pkg::*;
#(
  parameter int pointer_width = DEFAULT_POINTER_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load_start,
  input  logic                      dump_start,
  input  logic                      in_valid,
  input  logic [REG_DATA_WIDTH-1:0] in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [REG_DATA_WIDTH-1:0] out_data,
  input  logic                      out_ready,
  output logic                      rf_write_enable,
  output logic [pointer_width-1:0]  rf_address,
  output logic [REG_DATA_WIDTH-1:0] rf_data_in,
  output logic                      rf_is_immediate,
  input  logic [REG_DATA_WIDTH-1:0] rf_data_out,
  output logic                      busy,
  output logic                      done
);
  seq_state_t           state;
  logic [pointer_width:0] count;
  logic                 last;
  always_comb begin
    in_ready        = state == LOAD;
    out_valid       = state == DUMP_SEND;
    busy            = state != IDLE;
    rf_write_enable = in_valid & in_ready;
    rf_data_in      = rf_write_enable ? in_data : '0;
    rf_address      = count[pointer_width-1:0];
    rf_is_immediate = 1'b0;
    last            = &count[pointer_width-1:0];
  end
  // done defaults low so it pulses for exactly the first IDLE cycle after completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            count <= '0;
          end else if (dump_start) begin
            state <= DUMP_READ;
            count <= '0;
          end
        end
        LOAD: begin
          if (rf_write_enable) begin
            count <= count + 1'b1;
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DUMP_READ: begin
          out_data <= rf_data_out;
          state    <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (out_ready) begin
            count <= count + 1'b1;
            state <= last ? IDLE : DUMP_READ;
            done  <= last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_file_sequencer.sv
// tb_register_file_sequencer: randomized self-checking bench with a behavioural bank model.
module tb_register_file_sequencer;
  import register_file_pkg::*;
  localparam int PW = 3;
  localparam int DEPTH = 1 << PW;
  logic clock = 1'b0, reset_n = 1'b1, load_start = 1'b0, dump_start = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic in_ready, out_valid, rf_write_enable, rf_is_immediate, busy, done;
  logic [7:0] out_data, rf_data_in, rf_data_out;
  logic [PW-1:0] rf_address;
  logic [7:0] bank [DEPTH];
  logic [7:0] exp_bank [DEPTH];
  logic [7:0] stim [DEPTH];
  int checks = 0, failures = 0;

  register_file_sequencer #(.pointer_width(PW)) dut (
    .clock(clock), .reset_n(reset_n), .load_start(load_start), .dump_start(dump_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rf_write_enable(rf_write_enable), .rf_address(rf_address), .rf_data_in(rf_data_in),
    .rf_is_immediate(rf_is_immediate), .rf_data_out(rf_data_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // stand-in for register_file: combinational read, write at the clock edge, no reset
  always @(posedge clock) if (rf_write_enable && !rf_is_immediate) bank[rf_address] <= rf_data_in;
  assign rf_data_out = bank[rf_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_we"}, rf_write_enable, 0);
    chk({tag, "_addr"}, rf_address, 0);
    chk({tag, "_din"}, rf_data_in, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_imm"}, rf_is_immediate, 0);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, bank[i], exp_bank[i]);
  endtask

  task automatic random_stim();
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'($urandom);
  endtask

  // mode: 0 valid always high, 1 valid pattern 1,0,0,1, 2 random valid
  task automatic do_load(input int mode, input bit both, input int abort_after);
    int idx = 0, cyc = 0;
    logic v;
    @(negedge clock);
    load_start = 1'b1;
    dump_start = both;
    @(negedge clock);
    load_start = 1'b0;
    dump_start = 1'b0;
    while (idx < DEPTH && cyc < 200) begin
      if (idx == abort_after) begin
        in_valid = 1'b1;
        in_data = stim[idx];
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b0;
        return;
      end
      v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = stim[idx];
      dump_start = both && cyc == 2;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_we", rf_write_enable, v);
      chk("load_addr", rf_address, idx);
      chk("load_din", rf_data_in, v ? stim[idx] : 8'h0);
      chk("load_busy", busy, 1);
      chk("load_out_valid", out_valid, 0);
      chk("load_done_low", done, 0);
      @(negedge clock);
      if (v) begin
        exp_bank[idx] = stim[idx];
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    dump_start = 1'b0;
    if (idx < DEPTH) chk("load_timeout", idx, DEPTH);
    #1;
    chk("load_done", done, 1);
    chk("load_busy_after", busy, 0);
    chk("load_in_ready_after", in_ready, 0);
    @(negedge clock);
    #1;
    chk("load_done_pulse", done, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  // mode: 0 always ready, 1 three stall cycles on stall_idx, 2 random ready
  task automatic do_dump(input int mode, input int stall_idx);
    int idx = 0, guard = 0, stalls = 0;
    logic r;
    @(negedge clock);
    dump_start = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    while (idx < DEPTH && guard < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("dr_out_valid", out_valid, 0);
      chk("dr_addr", rf_address, idx);
      chk("dr_busy", busy, 1);
      chk("dr_we", rf_write_enable, 0);
      @(negedge clock);
      guard++;
      do begin
        r = mode == 0 ? 1'b1 : mode == 1 ? !(idx == stall_idx && stalls < 3) : 1'($urandom_range(0, 1));
        if (!r) stalls++;
        out_ready = r;
        #1;
        chk("ds_out_valid", out_valid, 1);
        chk("ds_out_data", out_data, exp_bank[idx]);
        chk("ds_addr", rf_address, idx);
        chk("ds_done_low", done, 0);
        @(negedge clock);
        guard++;
      end while (!r && guard < 500);
      idx++;
    end
    out_ready = 1'b0;
    if (idx < DEPTH) chk("dump_timeout", idx, DEPTH);
    #1;
    chk("dump_done", done, 1);
    chk("dump_busy_after", busy, 0);
    chk("dump_out_valid_after", out_valid, 0);
    @(negedge clock);
    #1;
    chk("dump_done_pulse", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("idle_in_ready_gated", in_ready, 0);
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'(DEPTH - 1 - i);
    do_load(0, 1'b0, -1);
    check_bank("bank_reverse");
    chk("rf_read_addr3", bank[3], 4);
    do_dump(0, -1);
    do_dump(1, 2);
    random_stim();
    do_load(0, 1'b0, -1);
    check_bank("bank_random");
    for (int i = 0; i < DEPTH; i++) stim[i] = 8'(DEPTH - 1 - i);
    do_load(1, 1'b0, -1);
    check_bank("bank_gaps");
    random_stim();
    do_load(0, 1'b1, -1);
    check_bank("bank_both_starts");
    repeat (3) @(negedge clock);
    #1;
    chk("no_dump_after_ignored", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      random_stim();
      do_load(2, 1'b0, -1);
      check_bank("bank_rand_load");
      do_dump(2, -1);
    end
    random_stim();
    do_load(0, 1'b0, 3);
    check_bank("bank_after_abort");
    random_stim();
    do_load(0, 1'b0, -1);
    check_bank("bank_reload");
    do_dump(0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
